kernel_a_stream_ctrl: RTL and testbench

//  Stream sequencer for the kernel_A pipeline (kernelTop_kernel_A).
//  - Accepts a job start, admits NTOT work-items through a valid/ready source port.
//  - Drives the kernel's stall input.
//  - Tracks per-stage occupancy with a valid shift register of depth LAT.
//  - Presents valid/ready to the sink and flags done after NTOT results are taken.
//  - Data words bypass this block; it generates control only.

---
 rtl/kernel_a_stream_ctrl_if.sv | 26 ++
 rtl/kernel_a_stream_ctrl.sv | 97 +++++++++
 tb/tb_kernel_a_stream_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/kernel_a_stream_ctrl_if.sv
// Control-side handshake bundle between the kernel_A stream sequencer and its environment.
// The sequencer takes the slave modport; whoever drives jobs and data takes the master modport.
interface kernel_a_stream_ctrl_if #(
  parameter int CNTW = 16
);
  logic            start;
  logic            src_valid;
  logic            src_ready;
  logic            snk_valid;
  logic            snk_ready;
  logic            stall;
  logic [CNTW-1:0] in_count;
  logic [CNTW-1:0] out_count;
  logic            busy;
  logic            done;

  modport master (
    output start, src_valid, snk_ready,
    input  src_ready, snk_valid, stall, in_count, out_count, busy, done
  );

  modport slave (
    input  start, src_valid, snk_ready,
    output src_ready, snk_valid, stall, in_count, out_count, busy, done
  );
endinterface

// File: rtl/kernel_a_stream_ctrl.sv
// Stream sequencer for kernel_A: admits NTOT items per job, drives the kernel stall and
// tracks in-flight items with a LAT-deep valid shift register; data words bypass this block.
module kernel_a_stream_ctrl #(
  parameter int LAT  = 2,
  parameter int NTOT = 1024,
  parameter int CNTW = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  kernel_a_stream_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNTW-1:0] NTOT_C  = CNTW'(NTOT);
  localparam logic [CNTW-1:0] LAST_C  = CNTW'(NTOT - 1);
  localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);

  logic [1:0]      state_q, state_d;
  logic [LAT-1:0]  vpipe_q, vpipe_d, vpipe_shift;
  logic [CNTW-1:0] in_count_q, in_count_d;
  logic [CNTW-1:0] out_count_q, out_count_d;

  logic busy, adv, src_ready, snk_valid, accept, deliver, restart;

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  // The pipe may move whenever the last stage is empty or its result is being taken.
  assign adv       = busy && (!vpipe_q[LAT-1] || bus.snk_ready);
  assign src_ready = (state_q == S_RUN) && adv && (in_count_q < NTOT_C);
  assign snk_valid = busy && vpipe_q[LAT-1];
  assign accept    = bus.src_valid && src_ready;
  assign deliver   = snk_valid && bus.snk_ready;
  assign restart   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Written as a loop so LAT=1 needs no special case.
  always_comb begin
    vpipe_shift = '0;
    for (int i = LAT - 1; i >= 1; i--) begin
      vpipe_shift[i] = vpipe_q[i-1];
    end
    vpipe_shift[0] = accept;
  end

  always_comb begin
    state_d     = state_q;
    vpipe_d     = vpipe_q;
    in_count_d  = in_count_q;
    out_count_d = out_count_q;

    if (restart) begin
      state_d     = S_RUN;
      vpipe_d     = '0;
      in_count_d  = '0;
      out_count_d = '0;
    end else begin
      if (adv) begin
        vpipe_d = vpipe_shift;
      end
      if (accept) begin
        in_count_d = in_count_q + ONE_C;
      end
      if (deliver) begin
        out_count_d = out_count_q + ONE_C;
      end
      if ((state_q == S_RUN) && accept && (in_count_q == LAST_C)) begin
        state_d = S_DRAIN;
      end
      if ((state_q == S_DRAIN) && deliver && (out_count_q == LAST_C)) begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      vpipe_q     <= '0;
      in_count_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      vpipe_q     <= vpipe_d;
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.src_ready = src_ready;
  assign bus.snk_valid = snk_valid;
  assign bus.stall     = !adv;
  assign bus.in_count  = in_count_q;
  assign bus.out_count = out_count_q;
  assign bus.busy      = busy;
  assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_kernel_a_stream_ctrl.sv
// Directed bench for kernel_a_stream_ctrl with LAT=2, NTOT=8: full-rate job, sink stall,
// input bubbles with ignored start pulses, mid-job reset and back-to-back jobs.
module tb_kernel_a_stream_ctrl;
  localparam int LAT  = 2;
  localparam int NTOT = 8;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  kernel_a_stream_ctrl_if #(.CNTW(CNTW)) bus ();

  kernel_a_stream_ctrl #(.LAT(LAT), .NTOT(NTOT), .CNTW(CNTW)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Checks every control output in one go for a given cycle.
  task automatic chk_all(input string tag, input logic e_rdy, input logic e_vld, input logic e_stall,
                         input int e_in, input int e_out, input logic e_busy, input logic e_done);
    chk({tag, ".src_ready"}, bus.src_ready, e_rdy);
    chk({tag, ".snk_valid"}, bus.snk_valid, e_vld);
    chk({tag, ".stall"},     bus.stall,     e_stall);
    chk({tag, ".in_count"},  bus.in_count,  e_in);
    chk({tag, ".out_count"}, bus.out_count, e_out);
    chk({tag, ".busy"},      bus.busy,      e_busy);
    chk({tag, ".done"},      bus.done,      e_done);
  endtask

  // Expected outputs for cycle i of a full-rate job (i=0 is the first RUN cycle).
  task automatic chk_full_rate(input string tag, input int i);
    chk_all($sformatf("%s[%0d]", tag, i),
            i < NTOT,
            (i >= LAT) && (i < NTOT + LAT),
            i >= NTOT + LAT,
            (i < NTOT) ? i : NTOT,
            (i <= LAT) ? 0 : ((i - LAT > NTOT) ? NTOT : i - LAT),
            i < NTOT + LAT,
            i == NTOT + LAT);
  endtask

  task automatic run_full_job(input string tag);
    bus.start = 1'b1;
    settle();
    tick();
    bus.start = 1'b0;
    bus.src_valid = 1'b1;
    bus.snk_ready = 1'b1;
    for (int i = 0; i <= NTOT + LAT; i++) begin
      settle();
      chk_full_rate(tag, i);
      tick();
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.src_valid = 1'b0;
    bus.snk_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    settle();
    chk_all("reset", 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    settle();
    chk_all("idle", 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);

    // T1: continuous flow, first result LAT cycles after the first accept
    run_full_job("t1");

    // T6 + T2: restart from DONE, then hold the sink off with the pipe full
    bus.start = 1'b1;
    settle();
    tick();
    bus.start = 1'b0;
    settle();
    chk_all("t6.restart", 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    tick();
    settle();
    chk_all("t2.fill1", 1'b1, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0);
    tick();
    bus.snk_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk_all($sformatf("t2.hold[%0d]", k), 1'b0, 1'b1, 1'b1, 2, 0, 1'b1, 1'b0);
      tick();
    end
    bus.snk_ready = 1'b1;
    for (int i = LAT; i <= NTOT + LAT; i++) begin
      settle();
      chk_full_rate("t2.resume", i);
      tick();
    end

    // T3 + T4: alternating source, start pulses in RUN (cycle 5) and DRAIN (cycle 15)
    bus.start = 1'b1;
    settle();
    tick();
    bus.start = 1'b0;
    for (int i = 0; i <= 17; i++) begin
      bus.src_valid = (i % 2 == 0);
      bus.start     = (i == 5) || (i == 15);
      settle();
      chk_all($sformatf("t3[%0d]", i),
              i <= 14,
              (i >= 2) && (i <= 16) && (i % 2 == 0),
              i == 17,
              ((i + 1) / 2 > NTOT) ? NTOT : (i + 1) / 2,
              (i >= 1) ? (i - 1) / 2 : 0,
              i < 17,
              i == 17);
      tick();
    end
    bus.start = 1'b0;

    // T5: reset while three items have been accepted
    bus.start = 1'b1;
    settle();
    tick();
    bus.start     = 1'b0;
    bus.src_valid = 1'b1;
    bus.snk_ready = 1'b1;
    tick();
    tick();
    tick();
    settle();
    chk("t5.pre_in_count", bus.in_count, 3);
    chk("t5.pre_snk_valid", bus.snk_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.src_valid = 1'b0;
    settle();
    chk_all("t5.after_rst", 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    run_full_job("t5.fresh");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
